// File: rtl/buzzer_seq.sv
// Programmable square-wave buzzer sequencer: N beeps of on_time clocks each, separated by
// off_time clocks of silence, with a run-time tone half-period. Outputs are all registered.
module buzzer_seq #(
  parameter int unsigned DIV_W = 20,
  parameter int unsigned DUR_W = 28,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [DIV_W-1:0] half_period,
  input  logic [DUR_W-1:0] on_time,
  input  logic [DUR_W-1:0] off_time,
  input  logic [CNT_W-1:0] repeat_n,
  output logic             beep,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TONE = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [DIV_W-1:0] r_half;
  logic [DUR_W-1:0] r_on;
  logic [DUR_W-1:0] r_off;
  logic [CNT_W-1:0] r_rem;
  logic [DIV_W-1:0] r_tone_cnt;
  logic [DUR_W-1:0] r_dur_cnt;
  logic             r_beep;
  logic             r_busy;
  logic             r_done;

  logic             w_req;
  logic             w_cfg_ok;
  logic             w_tone_end;
  logic             w_on_end;
  logic             w_off_end;
  logic             w_last;

  logic             w_load;
  logic [CNT_W-1:0] w_rem_nxt;
  logic [DIV_W-1:0] w_tone_nxt;
  logic [DUR_W-1:0] w_dur_nxt;
  logic             w_beep_nxt;
  logic             w_done_nxt;

  // Decoded conditions shared by the next-state and output logic
  always_comb begin
    w_req      = start && !abort;
    w_cfg_ok   = (half_period != '0) && (on_time != '0) && (repeat_n != '0);
    w_tone_end = (r_tone_cnt == r_half - DIV_W'(1));
    w_on_end   = (r_dur_cnt == r_on - DUR_W'(1));
    w_off_end  = (r_dur_cnt == r_off - DUR_W'(1));
    w_last     = (r_rem <= CNT_W'(1));
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; abort overrides every transition
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_req && w_cfg_ok) w_state_nxt = S_TONE;
      end
      S_TONE: begin
        if (w_on_end) begin
          if (w_last)               w_state_nxt = S_IDLE;
          else if (r_off != '0)     w_state_nxt = S_GAP;
          else                      w_state_nxt = S_TONE;
        end
      end
      S_GAP: begin
        if (w_off_end) w_state_nxt = S_TONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (abort) w_state_nxt = S_IDLE;
  end

  // Output / datapath next values; counters clear by default so every new beep starts fresh
  always_comb begin
    w_load     = 1'b0;
    w_rem_nxt  = r_rem;
    w_tone_nxt = '0;
    w_dur_nxt  = '0;
    w_beep_nxt = 1'b0;
    w_done_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_load    = 1'b1;
          w_rem_nxt = repeat_n;
          if (w_cfg_ok) w_beep_nxt = 1'b1;
          else          w_done_nxt = 1'b1;
        end
      end
      S_TONE: begin
        if (w_on_end) begin
          w_rem_nxt = r_rem - CNT_W'(1);
          if (w_last)             w_done_nxt = 1'b1;
          else if (r_off == '0)   w_beep_nxt = 1'b1;
        end else begin
          w_dur_nxt = r_dur_cnt + DUR_W'(1);
          if (w_tone_end) begin
            w_beep_nxt = ~r_beep;
          end else begin
            w_beep_nxt = r_beep;
            w_tone_nxt = r_tone_cnt + DIV_W'(1);
          end
        end
      end
      S_GAP: begin
        if (w_off_end) w_beep_nxt = 1'b1;
        else           w_dur_nxt  = r_dur_cnt + DUR_W'(1);
      end
      default: ;
    endcase
    if (abort) begin
      w_load     = 1'b0;
      w_rem_nxt  = '0;
      w_beep_nxt = 1'b0;
      w_done_nxt = 1'b0;
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_half     <= '0;
      r_on       <= '0;
      r_off      <= '0;
      r_rem      <= '0;
      r_tone_cnt <= '0;
      r_dur_cnt  <= '0;
      r_beep     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      if (w_load) begin
        r_half <= half_period;
        r_on   <= on_time;
        r_off  <= off_time;
      end
      r_rem      <= w_rem_nxt;
      r_tone_cnt <= w_tone_nxt;
      r_dur_cnt  <= w_dur_nxt;
      r_beep     <= w_beep_nxt;
      r_busy     <= (w_state_nxt != S_IDLE);
      r_done     <= w_done_nxt;
    end
  end

  assign beep = r_beep;
  assign busy = r_busy;
  assign done = r_done;

endmodule
